w_code_sequencer: RTL and testbench

Upstream stimulus stage that generates the 3-bit code word `W` consumed by the 3-to-2 code-mapping block. On `start` it emits a run of `run_len` codes in a selected order: binary up, binary down, Gray, or ping-pong. Each code is offered to the downstream stage under a valid/ready handshake. The block holds its position between runs, so consecutive runs continue the sequence unless reloaded.

---
 rtl/w_code_sequencer.sv | 131 +++++++++++++
 tb/tb_w_code_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/w_code_sequencer.sv
// w_code_sequencer: emits a run of 3-bit code words W (binary up, binary down,
// Gray, ping-pong) under a valid/ready handshake. The index is kept between runs,
// so a new run continues the sequence unless a load replaces the index.
// Optional feature: define W_SEQ_GRAY_EN to build the Gray encoder for mode 10.
// Without it, mode 10 behaves as binary up.
module w_code_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic [3:0] run_len,
  input  logic       w_ready,
  output logic [2:0] W,
  output logic       w_valid,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state;
  logic [2:0] idx;
  logic [1:0] m;
  logic [3:0] rem;   // 0 stands for 16: it counts down 0,15,...,1
  logic       dir;   // 1 = counting up (only used in ping-pong)

  logic       xfer;
  logic [2:0] sidx;  // index a run starts from (a load in the same cycle wins)
  logic [2:0] nidx;
  logic       ndir;
  logic       wrap_c;
  logic [2:0] code_src;
  logic [2:0] code_nxt;

  assign xfer = w_valid && w_ready;
  assign wrap = xfer && wrap_c;
  assign sidx = load ? load_val : idx;

  // Successor index, direction and wrap condition for the latched mode
  always_comb begin
    nidx   = idx;
    ndir   = dir;
    wrap_c = 1'b0;
    case (m)
      2'b01: begin
        nidx   = idx - 3'd1;
        wrap_c = (idx == 3'd0);
      end
      2'b11: begin
        if (dir && idx == 3'd7) begin
          nidx   = 3'd6;
          ndir   = 1'b0;
          wrap_c = 1'b1;
        end else if (!dir && idx == 3'd0) begin
          nidx   = 3'd1;
          ndir   = 1'b1;
          wrap_c = 1'b1;
        end else begin
          nidx = dir ? idx + 3'd1 : idx - 3'd1;
        end
      end
      // binary up, and Gray up which walks the same index order
      default: begin
        nidx   = idx + 3'd1;
        wrap_c = (idx == 3'd7);
      end
    endcase
  end

  // Index whose code goes into the W register at the next edge
  assign code_src = (state == S_IDLE) ? sidx : nidx;

`ifdef W_SEQ_GRAY_EN
  logic [1:0] code_md;
  assign code_md  = (state == S_IDLE) ? mode : m;
  assign code_nxt = (code_md == 2'b10) ? (code_src ^ (code_src >> 1)) : code_src;
`else
  assign code_nxt = code_src;
`endif

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      m       <= 2'b00;
      rem     <= 4'd0;
      dir     <= 1'b1;
      W       <= 3'd0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          idx <= sidx;
          if (start) begin
            m       <= mode;
            rem     <= run_len;
            dir     <= 1'b1;
            W       <= code_nxt;
            w_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            idx <= nidx;
            dir <= ndir;
            rem <= rem - 4'd1;
            W   <= code_nxt;
            if (rem == 4'd1) begin
              w_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w_code_sequencer.sv
// Bench for w_code_sequencer: a sequence model predicts every run's codes and
// wrap flags from position arithmetic; literal sequences pin the model.
module tb_w_code_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [3:0] run_len = 4'd0;
  logic       w_ready = 1'b1;
  logic [2:0] W;
  logic       w_valid, busy, done, wrap;

  w_code_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .load(load),
    .load_val(load_val), .run_len(run_len), .w_ready(w_ready), .W(W),
    .w_valid(w_valid), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Index reached after k steps from s in mode md
  function automatic int pos(input int md, input int s, input int k);
    int r;
    if (md == 1) return (((s - k) % 8) + 8) % 8;
    if (md == 3) begin
      r = (s + k) % 14;
      return (r <= 7) ? r : 14 - r;
    end
    return (s + k) % 8;
  endfunction

  function automatic bit pos_wrap(input int md, input int s, input int k);
    int r;
    if (md == 1) return pos(md, s, k) == 0;
    if (md == 3) begin
      r = (s + k) % 14;
      return (r == 7) || ((s + k) > 0 && r == 0);
    end
    return pos(md, s, k) == 7;
  endfunction

  // Model state
  int          m_idx = 0;
  bit          m_act = 1'b0;
  bit          m_dpend = 1'b0;
  bit          chk_rst = 1'b0;
  int          q_code[$];
  bit          q_wrap[$];
  logic [63:0] obs_c = '0;
  logic [63:0] obs_w = '0;
  int          obs_n = 0;

  // Compare process: checks outputs against the model every cycle
  always @(negedge clk) begin
    bit nd;
    int n, c;
    if (!rst_n) begin
      m_idx = 0; m_act = 0; m_dpend = 0; chk_rst = 1;
      q_code.delete(); q_wrap.delete();
    end else begin
      if (chk_rst) begin
        chk("rst_W", W, 0);
        chk("rst_valid", w_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk_rst = 0;
      end
      chk("w_valid", w_valid, m_act);
      chk("busy", busy, m_act);
      chk("done", done, m_dpend);
      nd = 0;
      if (w_valid && w_ready) begin
        obs_c = (obs_c << 3) | 64'(W);
        obs_w = (obs_w << 1) | 64'(wrap);
        obs_n++;
      end
      if (m_act) begin
        chk("W", W, q_code[0]);
        chk("wrap", wrap, w_ready ? q_wrap[0] : 1'b0);
        if (w_ready) begin
          void'(q_code.pop_front());
          void'(q_wrap.pop_front());
          if (q_code.size() == 0) begin
            m_act = 0;
            nd = 1;
          end
        end
      end else begin
        chk("wrap_idle", wrap, 0);
        if (!m_dpend) begin
          if (load) m_idx = load_val;
          if (start) begin
            n = (run_len == 0) ? 16 : run_len;
            for (int k = 0; k < n; k++) begin
              c = pos(mode, m_idx, k);
`ifdef W_SEQ_GRAY_EN
              if (mode == 2) c = c ^ (c >> 1);
`endif
              q_code.push_back(c);
              q_wrap.push_back(pos_wrap(mode, m_idx, k));
            end
            m_idx = pos(mode, m_idx, n);
            m_act = 1;
          end
        end
      end
      m_dpend = nd;
    end
  end

  task automatic obs_clr();
    obs_c = '0; obs_w = '0; obs_n = 0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy || done) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 200) chk("timeout_idle", 1, 0);
  endtask

  // One run; mode/run_len are scrambled after acceptance and must not matter
  task automatic run(input bit ld, input logic [2:0] lv, input logic [1:0] md,
                     input logic [3:0] rl);
    load = ld; load_val = lv; mode = md; run_len = rl; start = 1;
    @(posedge clk); #1;
    start = 0; load = 0; mode = ~md; run_len = 4'd5;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // binary up, 10 codes from 0
    obs_clr(); run(0, 0, 2'b00, 4'd10);
    chk("t1_codes", obs_c, {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7,3'd0,3'd1});
    chk("t1_wrap", obs_w, 10'b0000000100);
    chk("t1_n", obs_n, 10);

    // continues from idx 2
    obs_clr(); run(0, 0, 2'b00, 4'd2);
    chk("t1b_codes", obs_c, {3'd2,3'd3});

    // load+start same cycle, down
    obs_clr(); run(1, 3'd3, 2'b01, 4'd5);
    chk("t2_codes", obs_c, {3'd3,3'd2,3'd1,3'd0,3'd7});
    chk("t2_wrap", obs_w, 5'b00010);

    // standalone load, then ping-pong 16
    load = 1; load_val = 3'd0;
    @(posedge clk); #1;
    load = 0;
    obs_clr(); run(0, 0, 2'b11, 4'd0);
    chk("t3_codes", obs_c, {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7,
                            3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0,3'd1});
    chk("t3_wrap", obs_w, 16'b0000000100000010);
    chk("t3_n", obs_n, 16);

    // Gray (or binary up without the encoder)
    obs_clr(); run(1, 3'd0, 2'b10, 4'd8);
`ifdef W_SEQ_GRAY_EN
    chk("t4_codes", obs_c, {3'd0,3'd1,3'd3,3'd2,3'd6,3'd7,3'd5,3'd4});
`else
    chk("t4_codes", obs_c, {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7});
`endif
    chk("t4_wrap", obs_w, 8'b00000001);

    // stalls plus start/load pulses inside the run
    obs_clr();
    mode = 2'b00; run_len = 4'd4; start = 1;
    @(posedge clk); #1;
    start = 0; w_ready = 1;
    @(posedge clk); #1;
    w_ready = 0; start = 1; load = 1; load_val = 3'd5;
    @(posedge clk); #1;
    start = 0; load = 0;
    @(posedge clk); #1;
    w_ready = 1;
    wait_idle();
    chk("t5_codes", obs_c, {3'd0,3'd1,3'd2,3'd3});
    chk("t5_n", obs_n, 4);

    // reset after 3 transfers
    obs_clr();
    mode = 2'b00; run_len = 4'd8; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("t6_codes", obs_c, {3'd4,3'd5,3'd6});
    chk("t6_n", obs_n, 3);
    @(posedge clk); #1;
    chk("t6_nodone", done, 0);
    obs_clr(); run(0, 0, 2'b00, 4'd3);
    chk("t6b_codes", obs_c, {3'd0,3'd1,3'd2});

    // start held through DONE: only the following IDLE cycle may accept it
    obs_clr();
    load = 1; load_val = 3'd0; mode = 2'b00; run_len = 4'd1; start = 1;
    @(posedge clk); #1;
    load = 0;
    repeat (3) begin @(posedge clk); #1; end
    start = 0;
    wait_idle();
    chk("t7_codes", obs_c, {3'd0,3'd1});
    chk("t7_n", obs_n, 2);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
